// File: rtl/jtframe_joyproc_if.sv
// Player input/output bundle between the board merge logic and the joystick processor.
// The board side drives the raw active-high inputs and the core side reads the processed outputs.
interface jtframe_joyproc_if #(
    parameter int PLAYERS = 4,
    parameter int BUTTONS = 2
);
    localparam int JW = 4 + BUTTONS;

    logic [PLAYERS*JW-1:0] joy_in;
    logic [PLAYERS-1:0]    start_in;
    logic [PLAYERS-1:0]    coin_in;
    logic [PLAYERS*JW-1:0] game_joy;
    logic [PLAYERS-1:0]    game_start;
    logic [PLAYERS-1:0]    game_coin;

    modport master (
        output joy_in, start_in, coin_in,
        input  game_joy, game_start, game_coin
    );

    modport slave (
        input  joy_in, start_in, coin_in,
        output game_joy, game_start, game_coin
    );
endinterface

// File: rtl/jtframe_joyproc.sv
// Player input processor: sync, debounce, autofire, rotation and polarity of joystick/start/coin,
// plus a run/pause/single-frame-step controller and a frame counter.
module jtframe_joyproc #(
    parameter int PLAYERS    = 4,
    parameter int BUTTONS    = 2,
    parameter int ACTIVE_LOW = 1,
    parameter int DBWIDTH    = 12,
    parameter int AF_PERIOD  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vs,
    input  logic               lock,
    input  logic               rot,
    input  logic               flip,
    input  logic [BUTTONS-1:0] af_mask,
    input  logic               pause_key,
    input  logic               step_key,
    jtframe_joyproc_if.slave   io,
    output logic               game_pause,
    output logic [7:0]         frame_cnt
);
    localparam int JW = 4 + BUTTONS;
    localparam int NJ = PLAYERS * JW;
    localparam int DW = NJ + 2 * PLAYERS;   // debounced vector: {coin, start, joy}
    localparam int CW = 5 + BUTTONS;        // control vector: {af_mask, step, pause, flip, rot, vs}
    localparam logic POL = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {RUN, PAUSED, STEP_WAIT, STEP_RUN} state_t;

    logic [DW-1:0]      db_meta_reg, db_sync_reg;
    logic [CW-1:0]      ctl_meta_reg, ctl_sync_reg;
    logic [DBWIDTH-1:0] pre_reg;
    logic [DW-1:0]      s_prev_reg, deb_reg;
    logic               vs_l_reg, pause_l_reg, step_l_reg;
    logic [3:0]         af_cnt_reg;
    logic               af_on_reg;
    logic [7:0]         frame_cnt_reg;
    state_t             state_reg, state_next;
    logic               game_pause_reg;
    logic [NJ-1:0]      game_joy_reg;
    logic [PLAYERS-1:0] game_start_reg, game_coin_reg;

    logic               tick;
    logic [DW-1:0]      stable;
    logic               vs_s, rot_s, flip_s, pause_s, step_s;
    logic [BUTTONS-1:0] af_mask_s;
    logic               vs_rise, vs_fall, pause_edge, step_edge;
    logic [NJ-1:0]      joy_proc;

    assign vs_s      = ctl_sync_reg[0];
    assign rot_s     = ctl_sync_reg[1];
    assign flip_s    = ctl_sync_reg[2];
    assign pause_s   = ctl_sync_reg[3];
    assign step_s    = ctl_sync_reg[4];
    assign af_mask_s = ctl_sync_reg[5 +: BUTTONS];

    assign vs_rise    =  vs_s & ~vs_l_reg;
    assign vs_fall    = ~vs_s &  vs_l_reg;
    assign pause_edge = pause_s & ~pause_l_reg;
    assign step_edge  = step_s  & ~step_l_reg;

    assign tick   = &pre_reg;
    assign stable = ~(db_sync_reg ^ s_prev_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_meta_reg  <= '0;
            db_sync_reg  <= '0;
            ctl_meta_reg <= '0;
            ctl_sync_reg <= '0;
            pre_reg      <= '0;
            s_prev_reg   <= '0;
            deb_reg      <= '0;
            vs_l_reg     <= 1'b0;
            pause_l_reg  <= 1'b0;
            step_l_reg   <= 1'b0;
        end else begin
            db_meta_reg  <= {io.coin_in, io.start_in, io.joy_in};
            db_sync_reg  <= db_meta_reg;
            ctl_meta_reg <= {af_mask, step_key, pause_key, flip, rot, vs};
            ctl_sync_reg <= ctl_meta_reg;
            pre_reg      <= pre_reg + DBWIDTH'(1);
            vs_l_reg     <= vs_s;
            pause_l_reg  <= pause_s;
            step_l_reg   <= step_s;
            // A bit only moves once two consecutive tick samples agree on it
            if (tick) begin
                s_prev_reg <= db_sync_reg;
                deb_reg    <= (deb_reg & ~stable) | (db_sync_reg & stable);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            af_cnt_reg    <= '0;
            af_on_reg     <= 1'b1;
            frame_cnt_reg <= '0;
        end else if (vs_rise) begin
            frame_cnt_reg <= frame_cnt_reg + 8'd1;
            if (af_cnt_reg == 4'(AF_PERIOD - 1)) begin
                af_cnt_reg <= '0;
                af_on_reg  <= ~af_on_reg;
            end else begin
                af_cnt_reg <= af_cnt_reg + 4'd1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < PLAYERS; gi++) begin : g_player
            logic [JW-1:0]      raw;
            logic [BUTTONS-1:0] btn;
            logic [3:0]         dir;

            assign raw = deb_reg[gi*JW +: JW];
            // Masked buttons are blanked during the off half of the autofire cycle
            assign btn = raw[JW-1:4] & ~(af_mask_s & {BUTTONS{~af_on_reg}});

            always_comb begin
                dir = raw[3:0];
                if (rot_s) begin
                    dir = flip_s ? {raw[1], raw[0], raw[2], raw[3]}
                                 : {raw[0], raw[1], raw[3], raw[2]};
                end
            end

            assign joy_proc[gi*JW +: JW] = {btn, dir};
        end
    endgenerate

    // lock acts on the output register directly so it takes effect on the next edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst || lock) begin
            game_joy_reg   <= {NJ{POL}};
            game_start_reg <= {PLAYERS{POL}};
            game_coin_reg  <= {PLAYERS{POL}};
        end else begin
            game_joy_reg   <= joy_proc ^ {NJ{POL}};
            game_start_reg <= deb_reg[NJ +: PLAYERS] ^ {PLAYERS{POL}};
            game_coin_reg  <= deb_reg[NJ+PLAYERS +: PLAYERS] ^ {PLAYERS{POL}};
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:       if (pause_edge) state_next = PAUSED;
            PAUSED:    if (pause_edge) state_next = RUN;
                       else if (step_edge) state_next = STEP_WAIT;
            STEP_WAIT: if (pause_edge) state_next = RUN;
                       else if (vs_fall) state_next = STEP_RUN;
            STEP_RUN:  if (pause_edge) state_next = RUN;
                       else if (vs_fall) state_next = PAUSED;
            default:   state_next = RUN;
        endcase
        if (lock) state_next = RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= RUN;
            game_pause_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            game_pause_reg <= (state_next == PAUSED) || (state_next == STEP_WAIT);
        end
    end

    assign io.game_joy   = game_joy_reg;
    assign io.game_start = game_start_reg;
    assign io.game_coin  = game_coin_reg;
    assign game_pause    = game_pause_reg;
    assign frame_cnt     = frame_cnt_reg;
endmodule
